// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, arctangent table and vectoring FSM state type
// State COMP exists only when CORDIC_VEC_GAIN_COMP_EN is defined.
package cordic_pkg;

    localparam int          CORDIC_ITER = 31;
    localparam logic [31:0] CORDIC_KINV = 32'h9B74EDA8;
    localparam int          XY_W        = 42;
    localparam int          Z_W         = 32;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ITER,
`ifdef CORDIC_VEC_GAIN_COMP_EN
        COMP,
`endif
        DONE
    } cordic_state_t;

    // atan(2^-i) scaled so that 2^32 is a full turn, truncated toward zero
    function automatic logic [31:0] cordic_atan(input logic [4:0] idx);
        case (idx)
            5'd0:    return 32'h20000000;
            5'd1:    return 32'h12E4051D;
            5'd2:    return 32'h09FB385B;
            5'd3:    return 32'h051111D4;
            5'd4:    return 32'h028B0D43;
            5'd5:    return 32'h0145D7E1;
            5'd6:    return 32'h00A2F61E;
            5'd7:    return 32'h00517C55;
            5'd8:    return 32'h0028BE53;
            5'd9:    return 32'h00145F2E;
            5'd10:   return 32'h000A2F98;
            5'd11:   return 32'h000517CC;
            5'd12:   return 32'h00028BE6;
            5'd13:   return 32'h000145F3;
            5'd14:   return 32'h0000A2F9;
            5'd15:   return 32'h0000517C;
            5'd16:   return 32'h000028BE;
            5'd17:   return 32'h0000145F;
            5'd18:   return 32'h00000A2F;
            5'd19:   return 32'h00000517;
            5'd20:   return 32'h0000028B;
            5'd21:   return 32'h00000145;
            5'd22:   return 32'h000000A2;
            5'd23:   return 32'h00000051;
            5'd24:   return 32'h00000028;
            5'd25:   return 32'h00000014;
            5'd26:   return 32'h0000000A;
            5'd27:   return 32'h00000005;
            5'd28:   return 32'h00000002;
            5'd29:   return 32'h00000001;
            default: return 32'h00000000;
        endcase
    endfunction

endpackage

// File: rtl/cordic_vec_if.sv
// rtl/cordic_vec_if.sv - operand/result handshake bundle for cordic_vec
interface cordic_vec_if ();

    logic               in_valid;
    logic               in_ready;
    logic signed [39:0] xi;
    logic signed [39:0] yi;
    logic               out_valid;
    logic               out_ready;
    logic        [41:0] mag;
    logic        [31:0] angle;

    modport master (
        output in_valid, xi, yi, out_ready,
        input  in_ready, out_valid, mag, angle
    );

    modport slave (
        input  in_valid, xi, yi, out_ready,
        output in_ready, out_valid, mag, angle
    );

endinterface

// File: rtl/cordic_vec_iter.sv
// rtl/cordic_vec_iter.sv - one combinational CORDIC vectoring micro-rotation
module cordic_vec_iter
    import cordic_pkg::*;
(
    input  logic signed [XY_W-1:0] x,
    input  logic signed [XY_W-1:0] y,
    input  logic        [Z_W-1:0]  z,
    input  logic        [4:0]      i,
    output logic signed [XY_W-1:0] x_next,
    output logic signed [XY_W-1:0] y_next,
    output logic        [Z_W-1:0]  z_next
);

    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;
    logic        [Z_W-1:0]  step;

    assign x_sh = x >>> i;
    assign y_sh = y >>> i;
    assign step = cordic_atan(i);

    // drive y toward zero; z accumulates the angle rotated away
    always_comb begin
        x_next = x;
        y_next = y;
        z_next = z;
        if (!y[XY_W-1]) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + step;
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - step;
        end
    end

endmodule

// File: rtl/cordic_vec.sv
// rtl/cordic_vec.sv - iterative CORDIC vectoring unit (magnitude, atan2); CORDIC_VEC_GAIN_COMP_EN adds gain compensation
module cordic_vec
    import cordic_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    cordic_vec_if.slave bus
);

    cordic_state_t          state;
    logic signed [XY_W-1:0] x;
    logic signed [XY_W-1:0] y;
    logic        [Z_W-1:0]  z;
    logic        [4:0]      iter_cnt;
    logic                   zero;

    logic signed [XY_W-1:0] x_next;
    logic signed [XY_W-1:0] y_next;
    logic        [Z_W-1:0]  z_next;

    cordic_vec_iter u_iter (
        .x      (x),
        .y      (y),
        .z      (z),
        .i      (iter_cnt),
        .x_next (x_next),
        .y_next (y_next),
        .z_next (z_next)
    );

`ifdef CORDIC_VEC_GAIN_COMP_EN
    logic [XY_W-1:0] comp_mag;

    // x is non-negative after vectoring, so an unsigned Q0.32 multiply is exact
    assign comp_mag = XY_W'(({32'd0, x} * {42'd0, CORDIC_KINV}) >> 32);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.mag       <= '0;
            bus.angle     <= '0;
            x             <= '0;
            y             <= '0;
            z             <= '0;
            iter_cnt      <= '0;
            zero          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        x            <= {{2{bus.xi[39]}}, bus.xi};
                        y            <= {{2{bus.yi[39]}}, bus.yi};
                        bus.in_ready <= 1'b0;
                        state        <= PRE;
                    end
                end
                PRE: begin
                    // fold the left half-plane into the right so iterations converge
                    if (x[XY_W-1] && !y[XY_W-1]) begin
                        x <= y;
                        y <= -x;
                        z <= 32'h40000000;
                    end else if (x[XY_W-1] && y[XY_W-1]) begin
                        x <= -y;
                        y <= x;
                        z <= 32'hC0000000;
                    end else begin
                        z <= '0;
                    end
                    zero     <= (x == '0) && (y == '0);
                    iter_cnt <= '0;
                    state    <= ITER;
                end
                ITER: begin
                    x        <= x_next;
                    y        <= y_next;
                    z        <= z_next;
                    iter_cnt <= iter_cnt + 5'd1;
                    if (iter_cnt == 5'(CORDIC_ITER - 1)) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
                        state <= COMP;
`else
                        bus.mag       <= zero ? '0 : $unsigned(x_next);
                        bus.angle     <= zero ? '0 : z_next;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
`endif
                    end
                end
`ifdef CORDIC_VEC_GAIN_COMP_EN
                COMP: begin
                    bus.mag       <= zero ? '0 : comp_mag;
                    bus.angle     <= zero ? '0 : z;
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vec.sv
// tb/tb_cordic_vec.sv - randomized self-checking bench for cordic_vec against a real-arithmetic hypot/atan2 model
`timescale 1ns/1ps
module tb_cordic_vec;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    cordic_vec_if bus ();

    cordic_vec dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int  LAT_EXP = 33;
    localparam real GAIN    = 1.0;
`else
    localparam int  LAT_EXP = 32;
    localparam real GAIN    = 1.6467602581210656;
`endif
    localparam real TWO_PI  = 6.283185307179586;
    localparam real TURN    = 4294967296.0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint want, input longint tol = 0);
        longint d;
        d = got - want;
        n_checks++;
        if (d > tol || d < -tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, want, tol);
        end
    endtask

    // ideal result: gain * sqrt(x^2+y^2) and atan2 as a fraction of a full turn
    function automatic void ref_model(input longint xv, input longint yv,
                                      output longint m, output longint a, output longint m_tol);
        real rx, ry, r;
        if (xv == 0 && yv == 0) begin
            m = 0; a = 0; m_tol = 0;
            return;
        end
        rx    = real'(xv);
        ry    = real'(yv);
        r     = $sqrt(rx * rx + ry * ry);
        m     = longint'(r * GAIN);
        m_tol = 128 + longint'(r * GAIN / 268435456.0);
        a     = longint'($atan2(ry, rx) / TWO_PI * TURN);
    endfunction

    function automatic longint unwrap(input logic [31:0] got, input longint want);
        logic [31:0] want32, d;
        want32 = want[31:0];
        d      = got - want32;
        return want + longint'($signed(d));
    endfunction

    task automatic do_op(input string tag, input logic signed [39:0] xv, input logic signed [39:0] yv,
                         input int hold, input longint atol);
        longint m_exp, a_exp, m_tol, a_tol;
        int t, lat;
        ref_model(xv, yv, m_exp, a_exp, m_tol);
        a_tol = (xv == 0 && yv == 0) ? 0 : atol;
        bus.xi = xv; bus.yi = yv; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        t = 0;
        while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            check({tag, "/accept_timeout"}, 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // keep offering other operands while busy; they must not be taken
        bus.xi = 40'({$urandom(), $urandom()});
        bus.yi = 40'({$urandom(), $urandom()});
        lat = 0;
        while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
        check({tag, "/latency"}, lat, LAT_EXP);
        if (!bus.out_valid) begin
            bus.in_valid = 1'b0;
            return;
        end
        check({tag, "/mag"}, longint'(bus.mag), m_exp, m_tol);
        check({tag, "/angle"}, unwrap(bus.angle, a_exp), a_exp, a_tol);
        check({tag, "/busy_in_ready"}, longint'(bus.in_ready), 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, longint'(bus.out_valid), 1);
            check({tag, "/hold_mag"}, longint'(bus.mag), m_exp, m_tol);
            check({tag, "/hold_angle"}, unwrap(bus.angle, a_exp), a_exp, a_tol);
            check({tag, "/hold_in_ready"}, longint'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, "/post_out_valid"}, longint'(bus.out_valid), 0);
        check({tag, "/post_in_ready"}, longint'(bus.in_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [39:0] rx, ry;
        longint lx, ly;
        int t;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.xi = '0; bus.yi = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst/out_valid", longint'(bus.out_valid), 0);
        check("rst/mag", longint'(bus.mag), 0);
        check("rst/angle", longint'(bus.angle), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst/in_ready", longint'(bus.in_ready), 1);

        do_op("pos_x",  40'sd68719476736,  40'sd0,            0, 16);
        do_op("pos_y",  40'sd0,            40'sd68719476736,  0, 16);
        do_op("neg_x", -40'sd68719476736,  40'sd0,            0, 16);
        do_op("diag",   40'sd68719476736,  40'sd68719476736,  5, 16);
        do_op("ndiag", -40'sd68719476736, -40'sd68719476736,  0, 16);
        do_op("zero",   40'sd0,            40'sd0,            1, 0);
        do_op("q2",    -40'sd68719476736,  40'sd12345678901,  0, 16);
        do_op("min",   -40'sd549755813888, -40'sd549755813888, 0, 16);
        do_op("maxmin", 40'sd549755813887, -40'sd549755813888, 0, 16);
        do_op("minmax",-40'sd549755813888,  40'sd549755813887, 0, 16);

        // reset in the middle of the iterations
        bus.xi = 40'sd3000000000; bus.yi = -40'sd7000000000; bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 200) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst/out_valid", longint'(bus.out_valid), 0);
        check("midrst/mag", longint'(bus.mag), 0);
        check("midrst/angle", longint'(bus.angle), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst/in_ready", longint'(bus.in_ready), 1);
        do_op("after_rst", 40'sd3000000000, -40'sd7000000000, 0, 16);

        for (int n = 0; n < 20; n++) begin
            do begin
                rx = 40'({$urandom(), $urandom()});
                ry = 40'({$urandom(), $urandom()});
                lx = longint'(rx); ly = longint'(ry);
                if (lx < 0) lx = -lx;
                if (ly < 0) ly = -ly;
            end while (lx < 64'sd17179869184 && ly < 64'sd17179869184);
            do_op($sformatf("rand%0d", n), rx, ry, int'($urandom_range(0, 2)), 24);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_vec.md
CORDIC_VEC -- requirements
Module: cordic_vec

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: in_valid  input  1  the xi/yi operand pair is valid.
REQ-004 SHALL: in_ready  output  1  block can accept an operand pair.
REQ-005 SHALL: xi  input  40  signed x (cosine-side) component.
REQ-006 SHALL: yi  input  40  signed y (sine-side) component.
REQ-007 SHALL: out_valid  output  1  mag/angle are valid.
REQ-008 SHALL: out_ready  input  1  downstream accepts the result.
REQ-009 SHALL: mag  output  42  unsigned magnitude of (xi,yi).
REQ-010 SHALL: angle  output  32  signed atan2(yi,xi); 2^32 = 360 degrees, 0x40000000 = +90.

Function
REQ-011 SHALL: implement CORDIC vectoring mode (inverse of rotation mode): iterative, one micro-rotation per clk, 31 iterations (i=0..30).
REQ-012 SHALL: use FSM states IDLE, PRE, ITER, (COMP with macro), DONE.
REQ-013 SHALL: IDLE: in_ready=1; transfer on in_valid&in_ready captures xi/yi sign-extended to 42-bit x,y; go to PRE.
REQ-014 SHALL: PRE (1 cycle): if x<0 and y>=0: x=y, y=-x, z=0x40000000; if x<0 and y<0: x=-y, y=x, z=0xC0000000; else z=0; set zero flag if xi==0 and yi==0; go to ITER with counter i=0.
REQ-015 SHALL: ITER: if y>=0: x+=y>>>i, y-=x>>>i, z+=atan[i]; else x-=y>>>i, y+=x>>>i, z-=atan[i]; arithmetic shift; all updates use old x,y.
REQ-016 SHALL: z arithmetic wraps modulo 2^32; x,y held in 42 bits (no overflow for any 40-bit input).
REQ-017 SHALL: after i=30, go to DONE (or COMP with macro).
REQ-018 SHALL: DONE: out_valid=1; mag/angle held stable until out_valid&out_ready, then go to IDLE.
REQ-019 SHALL: accept-to-out_valid latency 32 cycles (33 with macro); no new operand accepted before the result handshake.
REQ-020 SHALL: zero flag forces mag=0, angle=0.
REQ-021 SHALL: in_valid while not IDLE is ignored (in_ready=0).

Reset
REQ-022 SHALL: reset_n low, at any time including mid-iteration, immediately force IDLE, in_ready=1 after release, out_valid=0, mag=0, angle=0, and clear x/y/z/counter/flags.

Configuration
REQ-023 SHALL: CORDIC_VEC_GAIN_COMP_EN defined: COMP state multiplies x by 32'h9B74EDA8 (0.607252935 in Q0.32), mag = product>>32 with upper bits zero.
REQ-024 SHALL: CORDIC_VEC_GAIN_COMP_EN undefined: no COMP state; mag = x raw, carrying gain 1.646760258.

Structure
REQ-025 SHALL: shared package cordic_pkg holds the 31-entry 32-bit atan table (entry0 = 0x20000000, entry1 = 0x12E4051D, ..., entry30 = 0), CORDIC_ITER=31, and CORDIC_KINV=32'h9B74EDA8.
REQ-026 SHALL: the combinational micro-rotation forms sub-module cordic_vec_iter (x,y,z,i in; x,y,z out); FSM and registers stay in cordic_vec.

Verification
REQ-027 SHALL: xi=2^36, yi=0 -> angle within +/-16 LSB of 0; mag ~ 1.64676*2^36 (no comp) or 2^36 +/-64 (comp).
REQ-028 SHALL: xi=0, yi=2^36 -> angle 0x40000000 +/-16; xi=-2^36, yi=0 -> angle 0x80000000 +/-16 (wrap allowed).
REQ-029 SHALL: xi=yi=2^36 -> angle 0x20000000 +/-16; mag (comp) 97184015999 +/-128; xi=yi=-2^36 -> angle 0xE0000000 +/-16.
REQ-030 SHALL: xi=yi=0 -> mag=0, angle=0 exactly, out_valid 32/33 cycles after accept.
REQ-031 SHALL: out_ready low 5 cycles in DONE -> outputs stable and in_ready=0; back-to-back operands then accepted one per result.
REQ-032 SHALL: reset_n pulsed at iteration 10 -> out_valid=0, mag=angle=0 immediately; next operand yields a correct result.
